// File: rtl/mac_stream_acc.sv
// Streaming multiply-accumulate engine.
// Takes (a, b) operand beats over a valid/ready handshake, multiplies each pair,
// and accumulates the products as signed or unsigned values, wrapping or
// saturating on overflow. When the beat marked last has been accumulated, one
// result beat is emitted with the beat count and a sticky overflow flag.
// Pipeline: stage 1 registers the product, stage 2 adds it to the accumulator.
module mac_stream_acc #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              mode_signed,
    input  logic              sat_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  count_out,
    output logic              ovf_out
);

    localparam int PW = 2 * DATA_W;
    localparam int XW = ACC_W + 1 - PW;

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]          state_q;
    logic                sgn_q;
    logic                sat_q;
    logic [PW-1:0]       p_q;
    logic                p_valid_q;
    logic                p_last_q;
    logic                done_q;
    logic [ACC_W-1:0]    acc_q;
    logic                ovf_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept;
    logic                first;
    logic                sgn_eff;
    logic signed [PW-1:0] prod_s;
    logic [PW-1:0]       prod_u;
    logic [PW-1:0]       prod;
    logic [ACC_W:0]      p_ext;
    logic [ACC_W:0]      acc_ext;
    logic [ACC_W:0]      sum;
    logic                add_ovf;
    logic [ACC_W-1:0]    acc_nxt;

    assign in_ready = (state_q == ST_ACC) && !clr;
    assign accept   = in_valid && in_ready;
    // An empty counter marks the first beat; its mode bits take effect at once.
    assign first    = (cnt_q == '0);
    assign sgn_eff  = first ? mode_signed : sgn_q;

    assign prod_s = $signed(a) * $signed(b);
    assign prod_u = a * b;
    assign prod   = sgn_eff ? prod_s : prod_u;

    // Stage-2 adder with one guard bit for overflow detection and clamping.
    always_comb begin
        p_ext   = sgn_q ? {{XW{p_q[PW-1]}}, p_q} : {{XW{1'b0}}, p_q};
        acc_ext = sgn_q ? {acc_q[ACC_W-1], acc_q} : {1'b0, acc_q};
        sum     = acc_ext + p_ext;
        add_ovf = sgn_q ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        acc_nxt = sum[ACC_W-1:0];
        if (add_ovf && sat_q) begin
            if (!sgn_q) begin
                acc_nxt = '1;
            end else if (sum[ACC_W]) begin
                acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    // Latch mode and saturation control on the first beat of a sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q <= 1'b0;
            sat_q <= 1'b0;
        end else if (accept && first) begin
            sgn_q <= mode_signed;
            sat_q <= sat_en;
        end
    end

    // Stage 1: product register plus valid/last tags; done_q marks the last add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q       <= '0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else if (clr) begin
            p_q       <= '0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            p_valid_q <= accept;
            p_last_q  <= accept && in_last;
            done_q    <= p_valid_q && p_last_q;
            if (accept) begin
                p_q <= prod;
            end
        end
    end

    // Stage 2: accumulator and sticky overflow, cleared when the result is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr || done_q) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (p_valid_q) begin
            acc_q <= acc_nxt;
            ovf_q <= ovf_q | add_ovf;
        end
    end

    // Beat counter, saturating at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || done_q) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers: loaded once the last product is in, held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            acc_out   <= '0;
            count_out <= '0;
            ovf_out   <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (done_q) begin
            out_valid <= 1'b1;
            acc_out   <= acc_q;
            count_out <= cnt_q;
            ovf_out   <= ovf_q;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sequence control: accept beats, drain the pipeline, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else if (clr) begin
            state_q <= ST_ACC;
        end else begin
            case (state_q)
                ST_ACC:   if (accept && in_last) state_q <= ST_FLUSH;
                ST_FLUSH: if (done_q) state_q <= ST_HOLD;
                ST_HOLD:  if (out_ready) state_q <= ST_ACC;
                default:  state_q <= ST_ACC;
            endcase
        end
    end

endmodule
